// File: rtl/ula_pkg.sv
// ============================================================================
// Module      : ula_pkg
// Description : Opcode constants and FSM state type shared by the ULA blocks.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package ula_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_SLL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ula_mul_seq.sv
// ============================================================================
// Module      : ula_mul_seq
// Description : Iterative shift-add multiplier, low WIDTH bits of a*b.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ula_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p,
    output logic             fin
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // The load cycle already performs the bit-0 step, leaving WIDTH-1 steps.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (load) begin
            acc_d    = b[0] ? a : '0;
            mcand_d  = a << 1;
            mplier_d = b >> 1;
            cnt_d    = CW'(WIDTH - 1);
        end else if (cnt_q != '0) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign p   = acc_q;
    assign fin = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/ula_mc.sv
// ============================================================================
// Module      : ula_mc
// Description : Multi-cycle ALU: single-cycle logic/arith ops, iterative MUL.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ula_mc
    import ula_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ULAControl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ULAResult,
    output logic             Z,
    output logic             C,
    output logic             V
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             z_q, z_d, c_q, c_d, v_q, v_d;

    logic [WIDTH:0]   sum_w, dif_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic             mul_load;
    logic [WIDTH-1:0] mul_p;
    logic             mul_fin;

    ula_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (mul_load),
        .a     (SrcA),
        .b     (SrcB),
        .p     (mul_p),
        .fin   (mul_fin)
    );

    // Single-cycle ops evaluate the live inputs; only their acceptance edge matters.
    always_comb begin
        sum_w   = {1'b0, SrcA} + {1'b0, SrcB};
        dif_w   = {1'b0, SrcA} + {1'b0, ~SrcB} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ULAControl)
            OP_ADD: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum_w[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif_w[WIDTH-1:0];
                alu_c   = dif_w[WIDTH];
                alu_v   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (dif_w[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_AND:  alu_res = SrcA & SrcB;
            OP_OR:   alu_res = SrcA | SrcB;
            OP_XOR:  alu_res = SrcA ^ SrcB;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
            OP_SLL:  alu_res = SrcA << SrcB[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        z_d      = z_q;
        c_d      = c_q;
        v_d      = v_q;
        mul_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (ULAControl == OP_MUL) begin
                        state_d  = RUN;
                        mul_load = 1'b1;
                    end else begin
                        state_d  = DONE;
                        result_d = alu_res;
                        z_d      = (alu_res == '0);
                        c_d      = alu_c;
                        v_d      = alu_v;
                    end
                end
            end
            RUN: begin
                if (mul_fin) begin
                    state_d  = DONE;
                    result_d = mul_p;
                    z_d      = (mul_p == '0);
                    c_d      = 1'b0;
                    v_d      = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            z_q      <= z_d;
            c_q      <= c_d;
            v_q      <= v_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign ULAResult = result_q;
    assign Z         = z_q;
    assign C         = c_q;
    assign V         = v_q;

endmodule

`default_nettype wire

// File: tb/tb_ula_mc.sv
// ============================================================================
// Module      : tb_ula_mc
// Description : Self-checking bench for ula_mc (WIDTH=8): vectors, corners, random.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ula_mc;

    localparam int W   = 8;
    localparam int SHW = $clog2(W);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] SrcA, SrcB;
    logic [2:0]   ULAControl;
    logic         busy, done, Z, C, V;
    logic [W-1:0] ULAResult;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ula_mc #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ULAControl (ULAControl),
        .busy       (busy),
        .done       (done),
        .ULAResult  (ULAResult),
        .Z          (Z),
        .C          (C),
        .V          (V)
    );

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
        logic [7:0]   lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the opcode meanings.
    function automatic vec_t ref_op(input logic [2:0] op, input logic [W-1:0] ai, input logic [W-1:0] bi);
        longint a, b, m, r, sa, sb, sr, lo, hi;
        vec_t   e;
        a  = longint'(ai);
        b  = longint'(bi);
        m  = (longint'(1) << W) - 1;
        lo = -(longint'(1) << (W-1));
        hi = (longint'(1) << (W-1)) - 1;
        sa = (a > hi) ? a - (m + 1) : a;
        sb = (b > hi) ? b - (m + 1) : b;
        e  = '0;
        r  = 0;
        case (op)
            3'd0: begin r = a + b; e.c = (r > m);  sr = sa + sb; e.v = (sr > hi) || (sr < lo); end
            3'd1: begin r = a - b; e.c = (a >= b); sr = sa - sb; e.v = (sr > hi) || (sr < lo); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (a < b) ? 1 : 0;
            3'd6: r = a * b;
            default: r = a << (b % (longint'(1) << SHW));
        endcase
        r      = r & m;
        e.op   = op;
        e.a    = ai;
        e.b    = bi;
        e.res  = r[W-1:0];
        e.z    = (r == 0);
        e.lat  = (op == 3'd6) ? 8'(W + 1) : 8'd1;
        return e;
    endfunction

    // Issue one op from mid-cycle, scramble inputs after acceptance, wait for done.
    task automatic run_op(input vec_t t, input string tag);
        int           lat;
        logic [W-1:0] res;
        logic         z, c, v;
        ULAControl = t.op;
        SrcA       = t.a;
        SrcB       = t.b;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        SrcA       = W'($urandom);
        SrcB       = W'($urandom);
        ULAControl = 3'($urandom);
        lat        = 1;
        check({tag, "_busy"}, busy, 1);
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        res = ULAResult;
        z = Z; c = C; v = V;
        check({tag, "_lat"}, lat, t.lat);
        check({tag, "_res"}, res, t.res);
        check({tag, "_z"}, z, t.z);
        check({tag, "_c"}, c, t.c);
        check({tag, "_v"}, v, t.v);
        tick();
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_held"}, ULAResult, t.res);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{op:3'd0, a:8'd200, b:8'd100, res:8'd44,   z:1'b0, c:1'b1, v:1'b0, lat:8'd1};
        vecs[1]  = '{op:3'd1, a:8'd5,   b:8'd5,   res:8'd0,    z:1'b1, c:1'b1, v:1'b0, lat:8'd1};
        vecs[2]  = '{op:3'd0, a:8'd127, b:8'd1,   res:8'd128,  z:1'b0, c:1'b0, v:1'b1, lat:8'd1};
        vecs[3]  = '{op:3'd6, a:8'd255, b:8'd255, res:8'd1,    z:1'b0, c:1'b0, v:1'b0, lat:8'd9};
        vecs[4]  = '{op:3'd5, a:8'd3,   b:8'd200, res:8'd1,    z:1'b0, c:1'b0, v:1'b0, lat:8'd1};
        vecs[5]  = '{op:3'd7, a:8'h81,  b:8'd9,   res:8'h02,   z:1'b0, c:1'b0, v:1'b0, lat:8'd1};
        vecs[6]  = '{op:3'd1, a:8'd3,   b:8'd5,   res:8'd254,  z:1'b0, c:1'b0, v:1'b0, lat:8'd1};
        vecs[7]  = '{op:3'd1, a:8'h80,  b:8'd1,   res:8'h7F,   z:1'b0, c:1'b1, v:1'b1, lat:8'd1};
        vecs[8]  = '{op:3'd2, a:8'hF0,  b:8'h3C,  res:8'h30,   z:1'b0, c:1'b0, v:1'b0, lat:8'd1};
        vecs[9]  = '{op:3'd3, a:8'hF0,  b:8'h0C,  res:8'hFC,   z:1'b0, c:1'b0, v:1'b0, lat:8'd1};
        vecs[10] = '{op:3'd4, a:8'hAA,  b:8'hAA,  res:8'h00,   z:1'b1, c:1'b0, v:1'b0, lat:8'd1};
        vecs[11] = '{op:3'd6, a:8'd16,  b:8'd16,  res:8'h00,   z:1'b1, c:1'b0, v:1'b0, lat:8'd9};

        rst_n = 1'b0; start = 1'b0; SrcA = '0; SrcB = '0; ULAControl = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res", ULAResult, 0);
        check("rst_zcv", {Z, C, V}, 0);

        // Release and request in the same slot: first edge with rst_n=1 must accept.
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // MUL 13*11 with start pulses in cycles 2 and 9 that must be ignored.
        ULAControl = 3'd6; SrcA = 8'd13; SrcB = 8'd11; start = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 9; cyc++) begin
            check($sformatf("mul_done_c%0d", cyc), done, (cyc == 9) ? 1 : 0);
            check($sformatf("mul_busy_c%0d", cyc), busy, 1);
            if (cyc == 9) check("mul_res", ULAResult, 143);
            if (cyc == 2 || cyc == 9) begin
                start = 1'b1; ULAControl = 3'd0; SrcA = 8'd1; SrcB = 8'd1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("mul_no_extra_done", done, 0);
            check("mul_no_extra_busy", busy, 0);
            check("mul_res_held", ULAResult, 143);
            tick();
        end

        // Reset in cycle 4 of a multiply.
        ULAControl = 3'd6; SrcA = 8'd7; SrcB = 8'd9; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_res", ULAResult, 0);
        check("abort_zcv", {Z, C, V}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            check("abort_no_done", done, 0);
            tick();
        end
        run_op('{op:3'd0, a:8'd1, b:8'd1, res:8'd2, z:1'b0, c:1'b0, v:1'b0, lat:8'd1}, "post_rst_add");

        for (int n = 0; n < 150; n++) begin
            logic [2:0]   op;
            logic [W-1:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = W'($urandom);
            b  = W'($urandom);
            if (n % 10 == 0) b = a;
            run_op(ref_op(op, a, b), $sformatf("rnd%0d_op%0d", n, op));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
